// File: rtl/arith_pkg.sv
// Shared types and constants for the iterative arithmetic unit.
package arith_pkg;

    // Operation codes; all four encodings are legal
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Quotient reported for a divide by zero; sliced down to the operand width
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle datapath shared by shift-add multiply and restoring divide.
// The hi/lo register pair holds {accumulator, multiplier} for MUL and
// {remainder, quotient-in-progress} for DIV.
module muldiv_iter
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             div_mode,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] operand_q;
    logic             div_q;
    logic [CW-1:0]    count_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    // The final iteration is the one applied while the counter reads 1
    assign last = (count_q == CW'(1));

    // Compute the value of the hi/lo pair after one more iteration
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, operand_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand_q};
        next_hi   = mul_sum[WIDTH:1];
        next_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};
        if (div_q) begin
            if (!div_diff[WIDTH]) begin
                next_hi = div_diff[WIDTH-1:0];
                next_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                next_hi = div_shift[WIDTH-1:0];
                next_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Load operands on start, then advance one iteration per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q      <= '0;
            lo_q      <= '0;
            operand_q <= '0;
            div_q     <= 1'b0;
            count_q   <= '0;
        end else if (start) begin
            hi_q      <= '0;
            lo_q      <= a;
            operand_q <= b;
            div_q     <= div_mode;
            count_q   <= CW'(WIDTH);
        end else if (step) begin
            hi_q      <= next_hi;
            lo_q      <= next_lo;
            count_q   <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/iterative_arith_unit.sv
// Handshaked arithmetic unit: single-cycle ADD/SUB and divide-by-zero,
// WIDTH-cycle MUL/DIV through the muldiv_iter datapath.
module iterative_arith_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry_out,
    output logic             div_by_zero
);

    state_t           state_q;
    state_t           state_d;
    op_t              op_in;
    logic             accept;
    logic             start_iter;
    logic             step_iter;
    logic             iter_last;
    logic             b_zero;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;

    assign op_in    = op_t'(op);
    assign b_zero   = (b == '0);
    assign add_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
    assign sub_full = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carry_in};

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_iter),
        .div_mode (op_in == OP_DIV),
        .step     (step_iter),
        .a        (a),
        .b        (b),
        .last     (iter_last),
        .next_hi  (iter_hi),
        .next_lo  (iter_lo)
    );

    // State register; reset drops straight back to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: single-cycle ops skip CALC, iterative ops stay for WIDTH cycles
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op_in == OP_MUL || (op_in == OP_DIV && !b_zero)) begin
                        state_d = CALC;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                if (iter_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs and datapath controls decoded from the current state
    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        step_iter  = (state_q == CALC);
        accept     = in_valid && in_ready;
        start_iter = accept && (op_in == OP_MUL || (op_in == OP_DIV && !b_zero));
    end

    // Result registers: written at accept for single-cycle ops, on the last iteration otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_lo   <= '0;
            result_hi   <= '0;
            carry_out   <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            unique case (op_in)
                OP_ADD: begin
                    result_lo   <= add_full[WIDTH-1:0];
                    result_hi   <= '0;
                    carry_out   <= add_full[WIDTH];
                    div_by_zero <= 1'b0;
                end
                OP_SUB: begin
                    result_lo   <= sub_full[WIDTH-1:0];
                    result_hi   <= '0;
                    carry_out   <= sub_full[WIDTH];
                    div_by_zero <= 1'b0;
                end
                OP_DIV: begin
                    if (b_zero) begin
                        result_lo   <= DIV_ZERO_QUOT[WIDTH-1:0];
                        result_hi   <= a;
                        carry_out   <= 1'b0;
                        div_by_zero <= 1'b1;
                    end
                end
                OP_MUL: begin
                end
                default: begin
                end
            endcase
        end else if (step_iter && iter_last) begin
            result_lo   <= iter_lo;
            result_hi   <= iter_hi;
            carry_out   <= 1'b0;
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iterative_arith_unit.sv
// Self-checking bench for iterative_arith_unit at WIDTH = 8: directed vector
// table, randomized traffic against an arithmetic reference model, and
// hand-written stall and mid-operation reset sequences.
module tb_iterative_arith_unit;

    localparam logic [1:0] C_ADD = 2'b00;
    localparam logic [1:0] C_SUB = 2'b01;
    localparam logic [1:0] C_MUL = 2'b10;
    localparam logic [1:0] C_DIV = 2'b11;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       carry_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result_lo;
    logic [7:0] result_hi;
    logic       carry_out;
    logic       div_by_zero;

    int checks;
    int failures;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        int         hold;
        logic [7:0] lo;
        logic [7:0] hi;
        logic       co;
        logic       dbz;
        int         lat;
    } vec_t;

    vec_t vecs[12];

    iterative_arith_unit #(
        .WIDTH(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .carry_in    (carry_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .carry_out   (carry_out),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation's definition
    task automatic modelOp(input logic [1:0] m_op, input logic [7:0] m_a, input logic [7:0] m_b,
                           input logic m_cin, output logic [7:0] e_lo, output logic [7:0] e_hi,
                           output logic e_co, output logic e_dbz, output int e_lat);
        int r;
        e_hi  = 8'd0;
        e_co  = 1'b0;
        e_dbz = 1'b0;
        e_lat = 1;
        case (m_op)
            C_ADD: begin
                r    = int'(m_a) + int'(m_b) + int'(m_cin);
                e_lo = 8'(r % 256);
                e_co = (r >= 256);
            end
            C_SUB: begin
                r    = int'(m_a) - int'(m_b) - int'(m_cin);
                e_co = (r < 0);
                if (r < 0) r = r + 256;
                e_lo = 8'(r);
            end
            C_MUL: begin
                r     = int'(m_a) * int'(m_b);
                e_lo  = 8'(r % 256);
                e_hi  = 8'(r / 256);
                e_lat = 9;
            end
            default: begin
                if (m_b == 8'd0) begin
                    e_lo  = 8'd255;
                    e_hi  = m_a;
                    e_dbz = 1'b1;
                end else begin
                    e_lo  = 8'(int'(m_a) / int'(m_b));
                    e_hi  = 8'(int'(m_a) % int'(m_b));
                    e_lat = 9;
                end
            end
        endcase
    endtask

    // One full transaction: accept, wait for the result while scrambling inputs,
    // stall for 'hold' cycles, then transfer with a competing request present
    task automatic applyStimulus(input logic [1:0] t_op, input logic [7:0] t_a, input logic [7:0] t_b,
                                 input logic t_cin, input int hold,
                                 output logic [7:0] r_lo, output logic [7:0] r_hi,
                                 output logic r_co, output logic r_dbz, output int lat,
                                 output logic busy_ok, output logic hold_ok);
        int guard;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        lat     = 0;
        guard   = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("ready_before_accept", 32'(in_ready), 32'd1);
        op       = t_op;
        a        = t_a;
        b        = t_b;
        carry_in = t_cin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (in_ready) busy_ok = 1'b0;
            in_valid = 1'($urandom);
            op       = 2'($urandom);
            a        = 8'($urandom);
            b        = 8'($urandom);
            carry_in = 1'($urandom);
        end
        r_lo  = result_lo;
        r_hi  = result_hi;
        r_co  = carry_out;
        r_dbz = div_by_zero;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            op       = 2'($urandom);
            a        = 8'($urandom);
            b        = 8'($urandom);
            @(negedge clk);
            if (result_lo !== r_lo || result_hi !== r_hi || carry_out !== r_co ||
                div_by_zero !== r_dbz || out_valid !== 1'b1 || in_ready !== 1'b0)
                hold_ok = 1'b0;
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        logic [7:0] g_lo;
        logic [7:0] g_hi;
        logic       g_co;
        logic       g_dbz;
        int         g_lat;
        logic       g_busy;
        logic       g_hold;
        logic [7:0] e_lo;
        logic [7:0] e_hi;
        logic       e_co;
        logic       e_dbz;
        int         e_lat;
        logic [1:0] r_op;
        logic [7:0] r_a;
        logic [7:0] r_b;
        logic       r_cin;
        logic       seen_valid;

        checks    = 0;
        failures  = 0;

        //            op     a     b    cin hold  lo     hi     co    dbz  lat
        vecs[0]  = '{C_ADD, 8'd200, 8'd100, 1'b1, 5, 8'd45,  8'd0,   1'b1, 1'b0, 1};
        vecs[1]  = '{C_SUB, 8'd5,   8'd7,   1'b0, 0, 8'd254, 8'd0,   1'b1, 1'b0, 1};
        vecs[2]  = '{C_SUB, 8'd7,   8'd5,   1'b1, 0, 8'd1,   8'd0,   1'b0, 1'b0, 1};
        vecs[3]  = '{C_MUL, 8'd255, 8'd255, 1'b1, 0, 8'h01,  8'hFE,  1'b0, 1'b0, 9};
        vecs[4]  = '{C_DIV, 8'd200, 8'd7,   1'b0, 2, 8'd28,  8'd4,   1'b0, 1'b0, 9};
        vecs[5]  = '{C_DIV, 8'd13,  8'd0,   1'b1, 0, 8'hFF,  8'd13,  1'b0, 1'b1, 1};
        vecs[6]  = '{C_MUL, 8'd0,   8'd123, 1'b0, 0, 8'd0,   8'd0,   1'b0, 1'b0, 9};
        vecs[7]  = '{C_DIV, 8'd5,   8'd9,   1'b0, 0, 8'd0,   8'd5,   1'b0, 1'b0, 9};
        vecs[8]  = '{C_ADD, 8'd255, 8'd0,   1'b1, 0, 8'd0,   8'd0,   1'b1, 1'b0, 1};
        vecs[9]  = '{C_DIV, 8'd255, 8'd1,   1'b0, 0, 8'd255, 8'd0,   1'b0, 1'b0, 9};
        vecs[10] = '{C_SUB, 8'd0,   8'd0,   1'b1, 0, 8'd255, 8'd0,   1'b1, 1'b0, 1};
        vecs[11] = '{C_MUL, 8'd16,  8'd16,  1'b0, 1, 8'd0,   8'd1,   1'b0, 1'b0, 9};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 2'b00;
        a         = 8'd0;
        b         = 8'd0;
        carry_in  = 1'b0;

        #2;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_result_lo", 32'(result_lo), 32'd0);
        checkOutput("reset_result_hi", 32'(result_hi), 32'd0);
        checkOutput("reset_carry_out", 32'(carry_out), 32'd0);
        checkOutput("reset_div_by_zero", 32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].hold,
                          g_lo, g_hi, g_co, g_dbz, g_lat, g_busy, g_hold);
            checkOutput($sformatf("vec%0d_lo", i), 32'(g_lo), 32'(vecs[i].lo));
            checkOutput($sformatf("vec%0d_hi", i), 32'(g_hi), 32'(vecs[i].hi));
            checkOutput($sformatf("vec%0d_carry", i), 32'(g_co), 32'(vecs[i].co));
            checkOutput($sformatf("vec%0d_dbz", i), 32'(g_dbz), 32'(vecs[i].dbz));
            checkOutput($sformatf("vec%0d_latency", i), 32'(g_lat), 32'(vecs[i].lat));
            checkOutput($sformatf("vec%0d_busy_not_ready", i), 32'(g_busy), 32'd1);
            checkOutput($sformatf("vec%0d_hold_stable", i), 32'(g_hold), 32'd1);
            checkOutput($sformatf("vec%0d_ready_after_xfer", i), 32'(in_ready), 32'd1);
            checkOutput($sformatf("vec%0d_valid_after_xfer", i), 32'(out_valid), 32'd0);
        end

        // Results linger in IDLE until the next operation overwrites them
        repeat (3) @(negedge clk);
        checkOutput("idle_retain_lo", 32'(result_lo), 32'd0);
        checkOutput("idle_retain_hi", 32'(result_hi), 32'd1);
        checkOutput("idle_no_spurious_valid", 32'(out_valid), 32'd0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            r_op  = 2'($urandom);
            r_a   = 8'($urandom);
            r_b   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            r_cin = 1'($urandom);
            modelOp(r_op, r_a, r_b, r_cin, e_lo, e_hi, e_co, e_dbz, e_lat);
            applyStimulus(r_op, r_a, r_b, r_cin, $urandom_range(0, 3),
                          g_lo, g_hi, g_co, g_dbz, g_lat, g_busy, g_hold);
            checkOutput($sformatf("rnd%0d_op%0d_lo", n, r_op), 32'(g_lo), 32'(e_lo));
            checkOutput($sformatf("rnd%0d_op%0d_hi", n, r_op), 32'(g_hi), 32'(e_hi));
            checkOutput($sformatf("rnd%0d_op%0d_carry", n, r_op), 32'(g_co), 32'(e_co));
            checkOutput($sformatf("rnd%0d_op%0d_dbz", n, r_op), 32'(g_dbz), 32'(e_dbz));
            checkOutput($sformatf("rnd%0d_op%0d_latency", n, r_op), 32'(g_lat), 32'(e_lat));
            checkOutput($sformatf("rnd%0d_busy_not_ready", n), 32'(g_busy), 32'd1);
            checkOutput($sformatf("rnd%0d_hold_stable", n), 32'(g_hold), 32'd1);
        end

        // Asynchronous reset four cycles into a multiply
        @(negedge clk);
        op       = C_MUL;
        a        = 8'd255;
        b        = 8'd255;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset_result_lo", 32'(result_lo), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        checkOutput("midreset_discarded", 32'(seen_valid), 32'd0);
        applyStimulus(C_ADD, 8'd3, 8'd4, 1'b0, 0, g_lo, g_hi, g_co, g_dbz, g_lat, g_busy, g_hold);
        checkOutput("post_reset_add_lo", 32'(g_lo), 32'd7);
        checkOutput("post_reset_add_hi", 32'(g_hi), 32'd0);
        checkOutput("post_reset_add_carry", 32'(g_co), 32'd0);
        checkOutput("post_reset_add_latency", 32'(g_lat), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iterative_arith_unit.md
ITERATIVE_ARITH_UNIT -- requirements
Module: iterative_arith_unit

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal values are 2 to 32.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  request present.
REQ-005 Port: in_ready  output  1  unit can accept a request.
REQ-006 Port: op  input  2  operation code: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-007 Port: a  input  WIDTH  unsigned operand A.
REQ-008 Port: b  input  WIDTH  unsigned operand B.
REQ-009 Port: carry_in  input  1  carry for ADD, borrow for SUB; ignored for MUL and DIV.
REQ-010 Port: out_valid  output  1  result present.
REQ-011 Port: out_ready  input  1  consumer accepts the result.
REQ-012 Port: result_lo  output  WIDTH  low result word.
REQ-013 Port: result_hi  output  WIDTH  high result word.
REQ-014 Port: carry_out  output  1  carry (ADD) or borrow (SUB); 0 for MUL and DIV.
REQ-015 Port: div_by_zero  output  1  DIV with b==0; 0 for every other case.

Function
REQ-016 The unit SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 Accept SHALL occur on in_valid && in_ready; op, a, b and carry_in are captured at accept.
REQ-019 Input changes after accept SHALL be ignored until the unit is next in IDLE.
REQ-020 ADD: {carry_out, result_lo} = a + b + carry_in, computed WIDTH+1 bits wide; result_hi = 0.
REQ-021 ADD transitions IDLE->DONE, so out_valid is asserted 1 cycle after accept.
REQ-022 SUB: {carry_out, result_lo} = a - b - carry_in, computed WIDTH+1 bits wide with wrap-around; carry_out = 1 means borrow; result_hi = 0.
REQ-023 SUB transitions IDLE->DONE, so out_valid is asserted 1 cycle after accept.
REQ-024 MUL: unsigned shift-add; {result_hi, result_lo} = a * b (2*WIDTH bits).
REQ-025 MUL SHALL spend exactly WIDTH cycles in CALC, so out_valid is asserted WIDTH+1 cycles after accept.
REQ-026 DIV (b != 0): unsigned restoring division; result_lo = quotient, result_hi = remainder.
REQ-027 DIV (b != 0) SHALL spend exactly WIDTH cycles in CALC, so out_valid is asserted WIDTH+1 cycles after accept.
REQ-028 DIV with b==0 SHALL transition IDLE->DONE with latency 1: result_lo = all ones, result_hi = a, div_by_zero = 1.
REQ-029 The iteration counter SHALL count WIDTH down to 1; CALC->DONE occurs when the counter reaches 1 and that cycle's iteration is applied.
REQ-030 In DONE, out_valid = 1 and all result outputs SHALL hold stable while out_ready = 0, for any number of cycles.
REQ-031 A transfer on out_valid && out_ready SHALL move the FSM DONE->IDLE; out_valid falls and in_ready rises on the next cycle.
REQ-032 No request is accepted in the transfer cycle.
REQ-033 Result outputs SHALL retain their last values in IDLE; only out_valid qualifies them.
REQ-034 Operation codes are fully decoded; no illegal encodings exist.

Reset
REQ-035 rst_n low SHALL force IDLE immediately, regardless of clock, from any state, including mid-CALC.
REQ-036 Reset values: out_valid 0, result_lo 0, result_hi 0, carry_out 0, div_by_zero 0, counter 0; in_ready = 1 (IDLE).
REQ-037 An operation interrupted by reset SHALL be discarded with no output, and the first accept after reset SHALL complete correctly.

Structure
REQ-038 Shared package arith_pkg SHALL hold the op_t enum (ADD/SUB/MUL/DIV), the state_t enum (IDLE/CALC/DONE) and the div-by-zero quotient constant.
REQ-039 The iterative datapath SHALL be one sub-module, muldiv_iter, containing the shift-add and restoring-subtract step, the accumulator/remainder registers and the counter.
REQ-040 The FSM, handshake and ADD/SUB logic SHALL live in the top module.

Verification (WIDTH = 8)
REQ-041 ADD a=200, b=100, carry_in=1 -> result_lo=45, carry_out=1, result_hi=0, out_valid 1 cycle after accept.
REQ-042 SUB a=5, b=7, carry_in=0 -> result_lo=254, carry_out=1; SUB a=7, b=5, carry_in=1 -> result_lo=1, carry_out=0.
REQ-043 MUL a=255, b=255 -> result_hi=0xFE, result_lo=0x01, out_valid exactly 9 cycles after accept; in_ready 0 throughout.
REQ-044 DIV a=200, b=7 -> result_lo=28, result_hi=4, latency 9; DIV a=13, b=0 -> result_lo=0xFF, result_hi=13, div_by_zero=1, latency 1.
REQ-045 DONE with out_ready=0 for 5 cycles, operand and in_valid toggling -> outputs stable, in_ready 0, nothing accepted; out_ready=1 -> in_ready=1 the following cycle.
REQ-046 rst_n asserted asynchronously 4 cycles into MUL -> out_valid 0 and in_ready 1 immediately; a following ADD 3+4 -> result_lo=7 after 1 cycle.
